// File: rtl/stub_stream_framer.sv
// stub_stream_framer
//   Buffers the merged 48-bit stub stream of each bunch crossing in a FIFO and
//   frames every event as: header {A5, BX}, data words, trailer {5A, BX, ovf, cnt}.
//   Framed words leave over a valid/ready interface with a registered head.
//
// Ports
//   clk        processing clock (rising edge)
//   reset      synchronous active-high reset, clears all state
//   new_event  one-cycle pulse at the start of each BX
//   BX         BX number, sampled with new_event
//   in_dat     merged data word; in_valid qualifies it
//   in_none    merger has no more data for the current event
//   out_dat    framed word; out_valid qualifies out_dat/out_last
//   out_ready  sink accepts the word (transfer on out_valid & out_ready)
//   out_last   out_dat is a trailer word
//   busy       collector not idle or FIFO non-empty
//   drop_cnt   saturating count of dropped data words
module stub_stream_framer #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_event,
    input  logic [2:0]  BX,
    input  logic [47:0] in_dat,
    input  logic        in_valid,
    input  logic        in_none,
    output logic [47:0] out_dat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic [15:0] drop_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_OPEN} state_t;

    state_t       state_reg;
    logic [1:0]   hold_reg;      // cycles spent in HOLD
    logic         pend_reg;      // trailer owed after a data word that arrived with in_none
    logic [2:0]   cur_bx_reg;
    logic [11:0]  cnt_reg;
    logic         ovf_reg;
    logic [15:0]  drop_cnt_reg;

    logic [48:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;    // occupancy, includes the entry shown on the output

    logic [47:0]  out_dat_reg;
    logic         out_last_reg;
    logic         out_valid_reg;

    logic [AW:0]   free;
    logic          wr_en;
    logic          wr_fire;
    logic          wr_last;
    logic [47:0]   wr_word;
    logic          accept;
    logic          drop;
    logic          pop;
    logic          load;
    logic [AW-1:0] rd_addr;
    logic [47:0]   header_word;
    logic [47:0]   trailer_word;

    assign free         = (AW+1)'(DEPTH) - count_reg;
    assign header_word  = {8'hA5, cur_bx_reg, 37'b0};
    assign trailer_word = {8'h5A, cur_bx_reg, ovf_reg, 24'b0, cnt_reg};

    // Write decode: at most one FIFO entry per cycle.
    always_comb begin
        wr_en   = 1'b0;
        wr_last = 1'b0;
        wr_word = '0;
        accept  = 1'b0;
        drop    = 1'b0;
        unique case (state_reg)
            S_HOLD: begin
                if (new_event) begin
                    wr_en   = 1'b1;
                    wr_last = 1'b1;
                    wr_word = trailer_word;
                end else if (hold_reg == 2'd0) begin
                    wr_en   = 1'b1;
                    wr_word = header_word;
                end
            end
            S_OPEN: begin
                if (new_event || pend_reg) begin
                    wr_en   = 1'b1;
                    wr_last = 1'b1;
                    wr_word = trailer_word;
                end else if (in_valid) begin
                    // Two slots stay reserved for this trailer and the next header.
                    if (free >= (AW+1)'(3)) begin
                        wr_en   = 1'b1;
                        wr_word = in_dat;
                        accept  = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (in_none) begin
                    wr_en   = 1'b1;
                    wr_last = 1'b1;
                    wr_word = trailer_word;
                end
            end
            default: ;
        endcase
    end

    // Guard against overrun even in the corner where reservation cannot hold.
    assign wr_fire = wr_en && (count_reg != (AW+1)'(DEPTH));

    // The head entry stays in the FIFO until it is transferred.
    assign pop     = out_valid_reg && out_ready;
    assign rd_addr = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    assign load    = pop ? (count_reg >= (AW+1)'(2))
                         : (!out_valid_reg && (count_reg != '0));

    // Collector FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            hold_reg     <= 2'd0;
            pend_reg     <= 1'b0;
            cur_bx_reg   <= 3'd0;
            cnt_reg      <= 12'd0;
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= 16'd0;
        end else begin
            if (drop && drop_cnt_reg != 16'hFFFF) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
            if (new_event) begin
                // Start of a new event from any state; a forced close has already
                // queued the old trailer this cycle.
                state_reg  <= S_HOLD;
                hold_reg   <= 2'd0;
                pend_reg   <= 1'b0;
                cur_bx_reg <= BX;
                cnt_reg    <= 12'd0;
                ovf_reg    <= 1'b0;
            end else begin
                unique case (state_reg)
                    S_IDLE: ;
                    S_HOLD: begin
                        if (hold_reg == 2'd2) begin
                            state_reg <= S_OPEN;
                        end else begin
                            hold_reg <= hold_reg + 2'd1;
                        end
                    end
                    S_OPEN: begin
                        if (pend_reg) begin
                            pend_reg  <= 1'b0;
                            state_reg <= S_IDLE;
                        end else begin
                            if (accept && cnt_reg != 12'hFFF) begin
                                cnt_reg <= cnt_reg + 12'd1;
                            end
                            if (drop) begin
                                ovf_reg <= 1'b1;
                            end
                            if (in_none) begin
                                if (in_valid) begin
                                    pend_reg <= 1'b1;
                                end else begin
                                    state_reg <= S_IDLE;
                                end
                            end
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    // FIFO storage (no reset so it maps onto block RAM)
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_reg] <= {wr_last, wr_word};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({wr_fire, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Registered head: reloads in the pop cycle for 1 word/cycle throughput.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_dat_reg   <= 48'd0;
            out_last_reg  <= 1'b0;
        end else begin
            if (load) begin
                {out_last_reg, out_dat_reg} <= mem[rd_addr];
            end
            if (pop || load) begin
                out_valid_reg <= load;
            end
        end
    end

    assign out_dat   = out_dat_reg;
    assign out_last  = out_last_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg != S_IDLE) || (count_reg != '0);
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_stub_stream_framer.sv
// tb_stub_stream_framer
//   Directed bench for stub_stream_framer (DEPTH=8). Expected framed words are
//   hand-computed constants queued before each event; an output monitor checks
//   every transfer against the queue and checks stall stability.
module tb_stub_stream_framer;

    logic        clk;
    logic        reset;
    logic        new_event;
    logic [2:0]  BX;
    logic [47:0] in_dat;
    logic        in_valid;
    logic        in_none;
    logic [47:0] out_dat;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int last_cnt = 0;
    logic rnd_ready = 1'b0;
    logic [48:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [47:0] prev_dat = '0;

    stub_stream_framer #(.DEPTH(8), .AW(3)) dut (
        .clk(clk),
        .reset(reset),
        .new_event(new_event),
        .BX(BX),
        .in_dat(in_dat),
        .in_valid(in_valid),
        .in_none(in_none),
        .out_dat(out_dat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic last, input logic [47:0] w);
        exp_q.push_back({last, w});
    endtask

    // Drives one cycle of input, then returns 1 time unit after the edge.
    task automatic cyc(input logic ne, input logic [2:0] bx, input logic v,
                       input logic [47:0] d, input logic none);
        new_event = ne;
        BX        = bx;
        in_valid  = v;
        in_dat    = d;
        in_none   = none;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        new_event = 1'b0;
        in_valid  = 1'b0;
        in_none   = 1'b0;
        $display("cyc ne=%0b bx=%0d v=%0b d=%h none=%0b | ov=%0b od=%h ol=%0b busy=%0b drop=%0d",
                 ne, bx, v, d, none, out_valid, out_dat, out_last, busy, drop_cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0, 48'd0, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            idle(1);
        end
        chk({tag, "_queue"}, exp_q.size(), 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Output monitor: transfers against the expected queue, stall stability.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_dat", out_dat, prev_dat);
                chk("stall_vld", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", exp_q.size(), 1);
                end else begin
                    logic [48:0] e;
                    e = exp_q.pop_front();
                    chk("out_dat", out_dat, e[47:0]);
                    chk("out_last", out_last, e[48]);
                    if (out_last) last_cnt++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_dat   = out_dat;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lc0;
        reset = 1'b1; new_event = 0; BX = 0; in_dat = 0; in_valid = 0; in_none = 0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_dat", out_dat, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);

        // Single event, BX=3, words 1..3 at T+4..T+6, in_none at T+8.
        push(0, 48'hA56000000000); push(0, 48'h1); push(0, 48'h2); push(0, 48'h3);
        push(1, 48'h5A6000000003);
        cyc(1, 3'd3, 0, 0, 0);             // T
        chk("lat_t1", out_valid, 0);
        idle(1);
        chk("lat_t2", out_valid, 0);
        idle(1);
        chk("lat_t3", out_valid, 1);
        idle(1);
        cyc(0, 0, 1, 48'h1, 0);
        cyc(0, 0, 1, 48'h2, 0);
        cyc(0, 0, 1, 48'h3, 0);
        idle(1);
        cyc(0, 0, 0, 0, 1);                // T+8
        wait_drain("single");
        chk("single_drop", drop_cnt, 0);

        // Empty event, BX=7.
        push(0, 48'hA5E000000000); push(1, 48'h5AE000000000);
        cyc(1, 3'd7, 0, 0, 0);
        idle(3);
        cyc(0, 0, 0, 0, 1);
        wait_drain("empty");

        // Backpressure / overflow: 10 words with the sink stalled.
        out_ready = 1'b0;
        push(0, 48'hA54000000000);
        for (int i = 0; i < 5; i++) push(0, 48'h100 + 48'(i));
        push(1, 48'h5A5000000005);
        cyc(1, 3'd2, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 48'h100 + 48'(i), 0);
        cyc(0, 0, 0, 0, 1);
        idle(1);
        chk("ovf_drop", drop_cnt, 5);
        chk("ovf_head", out_dat, 48'hA54000000000);
        chk("ovf_vld", out_valid, 1);
        out_ready = 1'b1;
        wait_drain("ovf");

        // Forced close: new_event BX=1 while OPEN after 2 words of BX=5.
        push(0, 48'hA5A000000000); push(0, 48'h11); push(0, 48'h12);
        push(1, 48'h5AA000000002); push(0, 48'hA52000000000); push(1, 48'h5A2000000000);
        cyc(1, 3'd5, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 48'h11, 0);
        cyc(0, 0, 1, 48'h12, 0);
        cyc(1, 3'd1, 1, 48'h99, 0);        // in_valid ignored on the close cycle
        idle(3);
        cyc(0, 0, 0, 0, 1);
        wait_drain("force");
        chk("force_drop", drop_cnt, 5);

        // Stall hold with random ready over 3 events; last word of BX=6 comes with in_none.
        lc0 = last_cnt;
        rnd_ready = 1'b1;
        push(0, 48'hA58000000000); push(0, 48'h41); push(0, 48'h42); push(1, 48'h5A8000000002);
        cyc(1, 3'd4, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 48'h41, 0);
        cyc(0, 0, 1, 48'h42, 0);
        cyc(0, 0, 0, 0, 1);
        wait_drain("stall_a");
        push(0, 48'hA5C000000000); push(0, 48'h61); push(0, 48'h62); push(0, 48'h63);
        push(1, 48'h5AC000000003);
        cyc(1, 3'd6, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 48'h61, 0);
        cyc(0, 0, 1, 48'h62, 0);
        cyc(0, 0, 1, 48'h63, 1);
        wait_drain("stall_b");
        push(0, 48'hA50000000000); push(0, 48'h7); push(1, 48'h5A0000000001);
        cyc(1, 3'd0, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 48'h7, 0);
        cyc(0, 0, 0, 0, 1);
        wait_drain("stall_c");
        rnd_ready = 1'b0;
        chk("stall_lasts", last_cnt - lc0, 3);

        // Reset mid-drain with 4 entries queued.
        out_ready = 1'b0;
        cyc(1, 3'd3, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 48'h21, 0);
        cyc(0, 0, 1, 48'h22, 0);
        cyc(0, 0, 1, 48'h23, 0);
        idle(2);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_vld", out_valid, 1);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_dat", out_dat, 0);
        chk("mid_rst_last", out_last, 0);
        out_ready = 1'b1;
        idle(4);
        chk("post_rst_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
